// File: rtl/matrix_stream_loader_if.sv
// rtl/matrix_stream_loader_if.sv - element stream, register-file write port and core control bundle
// master is the loader's view; slave is the feeder/core side.
interface matrix_stream_loader_if #(
  parameter int WORDLEN   = 16,
  parameter int IDX_WIDTH = 2
);
  logic [WORDLEN-1:0]   in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic                 wr_en;
  logic [IDX_WIDTH-1:0] wr_row;
  logic [IDX_WIDTH-1:0] wr_col;
  logic [WORDLEN-1:0]   wr_data;
  logic                 inv_start;
  logic                 inv_done;
  logic                 busy;
  logic                 frame_err;

  modport master (
    input  in_data, in_valid, in_last, inv_done,
    output in_ready, wr_en, wr_row, wr_col, wr_data, inv_start, busy, frame_err
  );

  modport slave (
    output in_data, in_valid, in_last, inv_done,
    input  in_ready, wr_en, wr_row, wr_col, wr_data, inv_start, busy, frame_err
  );
endinterface

// File: rtl/matrix_stream_loader.sv
// rtl/matrix_stream_loader.sv - loads a row-major element stream into the inversion core register file
// Writes are registered one cycle behind the accept; start is issued one cycle after the final write.
module matrix_stream_loader #(
  parameter int WORDLEN        = 16,
  parameter int MATRIX_ROWS    = 3,
  parameter int MATRIX_COLUMNS = 3,
  parameter int IDX_WIDTH      = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  matrix_stream_loader_if.master bus
);
  typedef enum logic [1:0] {LOAD, FLUSH, START, WAIT} state_t;

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] row_q, row_d;
  logic [IDX_WIDTH-1:0] col_q, col_d;
  logic                 wr_en_q, wr_en_d;
  logic [IDX_WIDTH-1:0] wr_row_q, wr_row_d;
  logic [IDX_WIDTH-1:0] wr_col_q, wr_col_d;
  logic [WORDLEN-1:0]   wr_data_q, wr_data_d;
  logic                 inv_start_q, inv_start_d;
  logic                 frame_err_q, frame_err_d;
  logic                 accept;
  logic                 at_last;
  logic                 at_row_end;

  assign accept     = bus.in_valid && (state_q == LOAD);
  assign at_row_end = (col_q == IDX_WIDTH'(MATRIX_COLUMNS - 1));
  assign at_last    = at_row_end && (row_q == IDX_WIDTH'(MATRIX_ROWS - 1));

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    wr_en_d     = 1'b0;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    wr_data_d   = wr_data_q;
    inv_start_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_row_d  = row_q;
          wr_col_d  = col_q;
          wr_data_d = bus.in_data;
          if (at_last && bus.in_last) begin
            state_d = FLUSH;
            row_d   = '0;
            col_d   = '0;
          end else if (at_last || bus.in_last) begin
            // Misframed matrix: keep the write, resynchronise to [0][0].
            frame_err_d = 1'b1;
            row_d       = '0;
            col_d       = '0;
          end else if (at_row_end) begin
            col_d = '0;
            row_d = row_q + IDX_WIDTH'(1);
          end else begin
            col_d = col_q + IDX_WIDTH'(1);
          end
        end
      end
      FLUSH: begin
        state_d     = START;
        inv_start_d = 1'b1;
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.inv_done) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= LOAD;
      row_q       <= '0;
      col_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      wr_data_q   <= '0;
      inv_start_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wr_en_q     <= wr_en_d;
      wr_row_q    <= wr_row_d;
      wr_col_q    <= wr_col_d;
      wr_data_q   <= wr_data_d;
      inv_start_q <= inv_start_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.busy      = (state_q != LOAD);
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_row    = wr_row_q;
  assign bus.wr_col    = wr_col_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.inv_start = inv_start_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb/tb_matrix_stream_loader.sv - directed self-checking bench for matrix_stream_loader
module tb_matrix_stream_loader;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   passed = 0;

  logic [15:0] m [9] = '{16'h4000, 16'h2000, 16'h0000, 16'h1000, 16'h3000,
                         16'h1000, 16'h2000, 16'h3000, 16'h6000};

  logic        o_en, o_ferr, o_start;
  logic [1:0]  o_row, o_col;
  logic [15:0] o_data;
  int          starts;

  matrix_stream_loader_if #(.WORDLEN(16), .IDX_WIDTH(2)) ifc ();

  matrix_stream_loader #(
    .WORDLEN(16), .MATRIX_ROWS(3), .MATRIX_COLUMNS(3), .IDX_WIDTH(2)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc.master)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    ifc.inv_done = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    ifc.in_data  = d;
    ifc.in_last  = last;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    o_en = ifc.wr_en; o_row = ifc.wr_row; o_col = ifc.wr_col;
    o_data = ifc.wr_data; o_ferr = ifc.frame_err; o_start = ifc.inv_start;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_last = 1'b0; ifc.inv_done = 1'b0; ifc.in_data = '0;
    tick();
    tick();
    checks++; if (ifc.wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", ifc.wr_en); else passed++;
    checks++; if (ifc.wr_data !== 16'h0) $display("FAIL reset_wr_data got %h want 0000", ifc.wr_data); else passed++;
    checks++; if ({ifc.wr_row, ifc.wr_col} !== 4'h0) $display("FAIL reset_wr_idx got %h want 0", {ifc.wr_row, ifc.wr_col}); else passed++;
    checks++; if ({ifc.inv_start, ifc.frame_err, ifc.busy} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {ifc.inv_start, ifc.frame_err, ifc.busy}); else passed++;
    RST = 1'b0;
    tick();
    checks++; if (ifc.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", ifc.in_ready); else passed++;
  endtask

  task automatic test_nominal();
    for (int i = 0; i < 9; i++) begin
      push(m[i], i == 8);
      checks++; if (o_en !== 1'b1) $display("FAIL nom_wr_en[%0d] got %b want 1", i, o_en); else passed++;
      checks++; if ({o_row, o_col} !== {2'(i / 3), 2'(i % 3)}) $display("FAIL nom_idx[%0d] got %0d,%0d want %0d,%0d", i, o_row, o_col, i / 3, i % 3); else passed++;
      checks++; if (o_data !== m[i]) $display("FAIL nom_data[%0d] got %h want %h", i, o_data, m[i]); else passed++;
      checks++; if ({o_start, o_ferr} !== 2'b00) $display("FAIL nom_ctrl[%0d] got %b want 00", i, {o_start, o_ferr}); else passed++;
    end
    checks++; if ({ifc.busy, ifc.in_ready} !== 2'b10) $display("FAIL nom_flush_busy got %b want 10", {ifc.busy, ifc.in_ready}); else passed++;
    tick();
    checks++; if ({ifc.inv_start, ifc.wr_en} !== 2'b10) $display("FAIL nom_start got %b want 10", {ifc.inv_start, ifc.wr_en}); else passed++;
    tick();
    checks++; if ({ifc.inv_start, ifc.busy, ifc.in_ready} !== 3'b010) $display("FAIL nom_wait got %b want 010", {ifc.inv_start, ifc.busy, ifc.in_ready}); else passed++;
  endtask

  task automatic test_holdoff();
    int writes = 0;
    int readies = 0;
    ifc.in_data  = 16'h1234;
    ifc.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ifc.wr_en) writes++;
      if (ifc.in_ready) readies++;
    end
    checks++; if (writes !== 0) $display("FAIL hold_writes got %0d want 0", writes); else passed++;
    checks++; if (readies !== 0) $display("FAIL hold_ready got %0d want 0", readies); else passed++;
    ifc.inv_done = 1'b1;
    tick();
    ifc.inv_done = 1'b0;
    checks++; if ({ifc.in_ready, ifc.busy, ifc.wr_en} !== 3'b100) $display("FAIL hold_release got %b want 100", {ifc.in_ready, ifc.busy, ifc.wr_en}); else passed++;
    push(16'h1234, 1'b0);
    checks++; if ({o_en, o_row, o_col, o_data} !== {1'b1, 4'h0, 16'h1234}) $display("FAIL hold_first_write got %b %0d,%0d %h want 1 0,0 1234", o_en, o_row, o_col, o_data); else passed++;
  endtask

  task automatic test_gapped();
    int gap_writes = 0;
    int bad = 0;
    starts = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push(m[i], i == 8);
      if (!(o_en && o_row == 2'(i / 3) && o_col == 2'(i % 3) && o_data == m[i])) bad++;
      for (int g = 0; g < 3; g++) begin
        tick();
        if (ifc.wr_en) gap_writes++;
        if (ifc.inv_start) begin
          starts++;
          if (!(i == 8 && g == 0)) bad++;
        end
      end
    end
    checks++; if (bad !== 0) $display("FAIL gap_sequence got %0d bad want 0", bad); else passed++;
    checks++; if (gap_writes !== 0) $display("FAIL gap_spurious got %0d want 0", gap_writes); else passed++;
    checks++; if (starts !== 1) $display("FAIL gap_starts got %0d want 1", starts); else passed++;
    ifc.inv_done = 1'b1;
    tick();
    ifc.inv_done = 1'b0;
    checks++; if ({ifc.busy, ifc.in_ready} !== 2'b01) $display("FAIL gap_done got %b want 01", {ifc.busy, ifc.in_ready}); else passed++;
  endtask

  task automatic test_early_last();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(m[i], 1'b0);
      if (o_ferr) errs++;
    end
    push(m[4], 1'b1);
    checks++; if (errs !== 0) $display("FAIL early_pre_err got %0d want 0", errs); else passed++;
    checks++; if ({o_en, o_ferr, o_row, o_col, o_data} !== {2'b11, 4'h5, 16'h3000}) $display("FAIL early_err got en%b err%b %0d,%0d %h want 1 1 1,1 3000", o_en, o_ferr, o_row, o_col, o_data); else passed++;
    tick();
    checks++; if ({ifc.inv_start, ifc.frame_err, ifc.in_ready} !== 3'b001) $display("FAIL early_after got %b want 001", {ifc.inv_start, ifc.frame_err, ifc.in_ready}); else passed++;
    push(m[5], 1'b0);
    checks++; if ({o_en, o_ferr, o_row, o_col} !== {2'b10, 4'h0}) $display("FAIL early_resync got en%b err%b %0d,%0d want 1 0 0,0", o_en, o_ferr, o_row, o_col); else passed++;
  endtask

  task automatic test_missing_last();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(m[i], 1'b0);
      if (o_ferr) errs++;
    end
    push(m[8], 1'b0);
    checks++; if (errs !== 0) $display("FAIL miss_pre_err got %0d want 0", errs); else passed++;
    checks++; if ({o_en, o_ferr, o_row, o_col, o_data} !== {2'b11, 4'hA, 16'h6000}) $display("FAIL miss_err got en%b err%b %0d,%0d %h want 1 1 2,2 6000", o_en, o_ferr, o_row, o_col, o_data); else passed++;
    tick();
    checks++; if ({ifc.inv_start, ifc.busy, ifc.in_ready} !== 3'b001) $display("FAIL miss_after got %b want 001", {ifc.inv_start, ifc.busy, ifc.in_ready}); else passed++;
    tick();
    checks++; if ({ifc.inv_start, ifc.busy} !== 2'b00) $display("FAIL miss_stay got %b want 00", {ifc.inv_start, ifc.busy}); else passed++;
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 6; i++) push(m[i], 1'b0);
    RST = 1'b1;
    #1;
    checks++; if ({ifc.wr_en, ifc.wr_row, ifc.wr_col, ifc.wr_data} !== 21'h0) $display("FAIL mid_async_wr got %h want 0", {ifc.wr_en, ifc.wr_row, ifc.wr_col, ifc.wr_data}); else passed++;
    checks++; if ({ifc.inv_start, ifc.frame_err, ifc.busy} !== 3'b000) $display("FAIL mid_async_ctrl got %b want 000", {ifc.inv_start, ifc.frame_err, ifc.busy}); else passed++;
    tick();
    RST = 1'b0;
    starts = 0;
    for (int i = 0; i < 9; i++) begin
      push(m[i], i == 8);
      if (!(o_en && o_row == 2'(i / 3) && o_col == 2'(i % 3) && o_data == m[i] && !o_ferr)) bad++;
      if (o_start) starts++;
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ifc.inv_start) starts++;
    end
    checks++; if (bad !== 0) $display("FAIL mid_reload got %0d bad want 0", bad); else passed++;
    checks++; if (starts !== 1) $display("FAIL mid_starts got %0d want 1", starts); else passed++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_holdoff();
    test_gapped();
    test_early_last();
    test_missing_last();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
